// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the issue-side hazard scoreboard.
package hazard_scoreboard_pkg;

  // Architectural register file geometry.
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;

  // In-flight writes per register: one each in EX, MEM and WB.
  localparam int INFLIGHT_DEPTH = 3;
  localparam int CNT_W          = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INFLIGHT_DEPTH);

  // Operand source selection used by the EX-stage forwarding mux.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2
  } fwd_sel_e;

  // True when a source index names the given register.
  function automatic logic src_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] reg_idx);
    return src == reg_idx;
  endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// Saturating up/down counter of in-flight writes to one register.
// Increment on issue, decrement on retire; both together cancel out.
// Errors are sticky until reset.
module hazard_reg_counter
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  // Count issues and retires, holding at the limits and latching errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_count == CNT_MAX) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if (i_dec && !i_inc) begin
      if (r_count == '0) begin
        r_underflow <= 1'b1;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard. Tracks in-flight register writes from ID
// issue to WB retire and raises the ID stall when a source operand is not
// yet available.
//
// Issue/retire semantics: an ID instruction issues (issue_fire) when it is
// valid, writes a register, is not stalled by hazard and the pipeline is not
// frozen. A WB write retires (retire_fire) whenever wb_WB_EN is high and the
// pipeline is not frozen. There is no back-pressure beyond hazard/freeze.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                forward_en,
  input  logic [REG_W-1:0]    src1,
  input  logic [REG_W-1:0]    src2,
  input  logic                two_src,
  input  logic                issue_valid,
  input  logic                issue_WB_EN,
  input  logic                issue_MEM_R_EN,
  input  logic [REG_W-1:0]    issue_Dest,
  input  logic                wb_WB_EN,
  input  logic [REG_W-1:0]    wb_Dest,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                overflow_err,
  output logic                underflow_err
);

  logic                r_ex_load_valid;
  logic [REG_W-1:0]    r_ex_load_dest;

  logic                w_issue_fire;
  logic                w_retire_fire;
  logic [CNT_W-1:0]    w_count [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [NUM_REGS-1:0] w_eff_pend;
  logic [NUM_REGS-1:0] w_overflow;
  logic [NUM_REGS-1:0] w_underflow;
  logic                w_load_hit;
  logic                w_pend_hit;

  assign w_issue_fire  = issue_valid & issue_WB_EN & ~hazard & ~freeze;
  assign w_retire_fire = wb_WB_EN & ~freeze;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign w_inc[g] = w_issue_fire  & (issue_Dest == REG_W'(g));
    assign w_dec[g] = w_retire_fire & (wb_Dest    == REG_W'(g));

    hazard_reg_counter u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_inc[g]),
      .i_dec      (w_dec[g]),
      .o_count    (w_count[g]),
      .o_overflow (w_overflow[g]),
      .o_underflow(w_underflow[g])
    );

    // The final retire of a register writes the regfile before the ID read,
    // so it no longer blocks a reader in the same cycle.
    assign w_eff_pend[g]   = (w_count[g] != '0) &
                             ~(w_dec[g] & (w_count[g] == CNT_W'(1)));
    assign pending_mask[g] = (w_count[g] != '0);
  end

  assign overflow_err  = |w_overflow;
  assign underflow_err = |w_underflow;

  // Source compare against the load in EX and against the pending set.
  always_comb begin
    w_load_hit = r_ex_load_valid &
                 (src_match(src1, r_ex_load_dest) |
                  (two_src & src_match(src2, r_ex_load_dest)));
    w_pend_hit = w_eff_pend[src1] | (two_src & w_eff_pend[src2]);
    hazard     = issue_valid & (forward_en ? w_load_hit : w_pend_hit);
  end

  // Tag the load entering EX; a bubble clears it, freeze holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_load_valid <= 1'b0;
      r_ex_load_dest  <= '0;
    end else if (!freeze) begin
      r_ex_load_valid <= w_issue_fire & issue_MEM_R_EN;
      r_ex_load_dest  <= issue_Dest;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        forward_en;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        issue_valid;
  logic        issue_WB_EN;
  logic        issue_MEM_R_EN;
  logic [3:0]  issue_Dest;
  logic        wb_WB_EN;
  logic [3:0]  wb_Dest;
  logic        hazard;
  logic [15:0] pending_mask;
  logic        overflow_err;
  logic        underflow_err;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .forward_en    (forward_en),
    .src1          (src1),
    .src2          (src2),
    .two_src       (two_src),
    .issue_valid   (issue_valid),
    .issue_WB_EN   (issue_WB_EN),
    .issue_MEM_R_EN(issue_MEM_R_EN),
    .issue_Dest    (issue_Dest),
    .wb_WB_EN      (wb_WB_EN),
    .wb_Dest       (wb_Dest),
    .hazard        (hazard),
    .pending_mask  (pending_mask),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    issue_valid    = 1'b0;
    issue_WB_EN    = 1'b0;
    issue_MEM_R_EN = 1'b0;
    issue_Dest     = 4'd0;
    wb_WB_EN       = 1'b0;
    wb_Dest        = 4'd0;
    src1           = 4'd0;
    src2           = 4'd0;
    two_src        = 1'b0;
    freeze         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_issue(input logic [3:0] dest, input logic is_load);
    issue_valid    = 1'b1;
    issue_WB_EN    = 1'b1;
    issue_MEM_R_EN = is_load;
    issue_Dest     = dest;
  endtask

  task automatic drive_retire(input logic [3:0] dest);
    wb_WB_EN = 1'b1;
    wb_Dest  = dest;
  endtask

  // Reader in ID that does not write: only exercises hazard.
  task automatic drive_reader(input logic [3:0] s1, input logic [3:0] s2, input logic two);
    issue_valid = 1'b1;
    issue_WB_EN = 1'b0;
    src1        = s1;
    src2        = s2;
    two_src     = two;
  endtask

  initial begin
    idle();
    forward_en = 1'b0;
    rst = 1'b1;
    #12;
    settle();
    check("reset_pending", 32'(pending_mask), 32'h0);
    check("reset_ovf", 32'(overflow_err), 32'h0);
    check("reset_unf", 32'(underflow_err), 32'h0);
    check("reset_hazard", 32'(hazard), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Issue ADD r3, retire it a few cycles later.
    drive_issue(4'd3, 1'b0);
    settle();
    check("add_issue_hazard", 32'(hazard), 32'h0);
    step();
    idle();
    settle();
    check("add_pending", 32'(pending_mask), 32'h0008);
    step();
    step();

    // Stall on pending r3 without forwarding, bypass on same-cycle retire.
    drive_reader(4'd3, 4'd0, 1'b0);
    settle();
    check("nofwd_stall", 32'(hazard), 32'h1);
    drive_retire(4'd3);
    settle();
    check("retire_bypass", 32'(hazard), 32'h0);
    step();
    idle();
    settle();
    check("add_retired", 32'(pending_mask), 32'h0000);

    // Load-use with forwarding.
    forward_en = 1'b1;
    drive_issue(4'd5, 1'b1);
    settle();
    check("ldr_issue_hazard", 32'(hazard), 32'h0);
    step();
    idle();
    drive_reader(4'd0, 4'd5, 1'b1);
    settle();
    check("load_use_src2", 32'(hazard), 32'h1);
    two_src = 1'b0;
    settle();
    check("load_use_one_src", 32'(hazard), 32'h0);
    two_src = 1'b1;
    settle();
    step();
    check("load_use_one_cycle", 32'(hazard), 32'h0);
    check("ldr_pending", 32'(pending_mask), 32'h0020);
    idle();
    drive_retire(4'd5);
    step();
    idle();
    settle();
    check("ldr_retired", 32'(pending_mask), 32'h0000);

    // Saturate r7 at three in-flight writes.
    forward_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_issue(4'd7, 1'b0);
      step();
    end
    idle();
    settle();
    check("r7_pending", 32'(pending_mask), 32'h0080);
    check("r7_no_ovf", 32'(overflow_err), 32'h0);
    drive_issue(4'd7, 1'b0);
    step();
    idle();
    settle();
    check("r7_ovf", 32'(overflow_err), 32'h1);
    // Count held at 3: two retires leave it pending, third clears it.
    drive_retire(4'd7);
    step();
    drive_reader(4'd7, 4'd0, 1'b0);
    drive_retire(4'd7);
    settle();
    check("r7_cnt2_stall", 32'(hazard), 32'h1);
    step();
    check("r7_still_pending", 32'(pending_mask), 32'h0080);
    settle();
    check("r7_cnt1_bypass", 32'(hazard), 32'h0);
    step();
    idle();
    settle();
    check("r7_cleared", 32'(pending_mask), 32'h0000);
    check("r7_ovf_sticky", 32'(overflow_err), 32'h1);

    // Underflow on r9, then simultaneous issue+retire on r2.
    check("pre_unf", 32'(underflow_err), 32'h0);
    drive_retire(4'd9);
    step();
    idle();
    settle();
    check("r9_unf", 32'(underflow_err), 32'h1);
    check("r9_pending", 32'(pending_mask), 32'h0000);
    drive_issue(4'd2, 1'b0);
    step();
    drive_retire(4'd2);
    settle();
    check("r2_both_hazard", 32'(hazard), 32'h0);
    step();
    idle();
    settle();
    check("r2_still_pending", 32'(pending_mask), 32'h0004);
    drive_reader(4'd2, 4'd0, 1'b0);
    drive_retire(4'd2);
    settle();
    check("r2_cnt1_bypass", 32'(hazard), 32'h0);
    step();
    idle();
    settle();
    check("r2_cleared", 32'(pending_mask), 32'h0000);
    check("unf_sticky", 32'(underflow_err), 32'h1);

    // Freeze holds counters and the load tag.
    forward_en = 1'b1;
    drive_issue(4'd6, 1'b1);
    step();
    idle();
    freeze = 1'b1;
    drive_issue(4'd4, 1'b0);
    settle();
    check("freeze_issue_hazard", 32'(hazard), 32'h0);
    step();
    step();
    idle();
    settle();
    check("freeze_no_r4", 32'(pending_mask), 32'h0040);
    freeze = 1'b1;
    drive_reader(4'd6, 4'd0, 1'b0);
    settle();
    check("tag_held_frozen", 32'(hazard), 32'h1);
    freeze = 1'b0;
    settle();
    check("tag_held", 32'(hazard), 32'h1);
    step();
    idle();

    // r15 is tracked like any other register.
    forward_en = 1'b0;
    drive_issue(4'd15, 1'b0);
    step();
    idle();
    settle();
    check("r15_pending", 32'(pending_mask), 32'h8040);

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_pending", 32'(pending_mask), 32'h0000);
    check("async_ovf", 32'(overflow_err), 32'h0);
    check("async_unf", 32'(underflow_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    drive_reader(4'd6, 4'd0, 1'b0);
    forward_en = 1'b1;
    settle();
    check("reset_tag_cleared", 32'(hazard), 32'h0);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Time bound for the whole run.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
